exec_stage: RTL and testbench

Execute stage that sits directly downstream of the 8×16 register file. It sequences two combinational register-file reads into operand latches A and B, passes B through a 1-bit shifter, computes an ALU result into latch C with Z/N/V status, and writes C back to the register file. A start/done handshake lets the controller issue one three-register operation (rd ← rn op shift(rm)) at a time.

---
 rtl/exec_stage_if.sv | 34 +++
 rtl/exec_stage.sv | 142 ++++++++++++++
 tb/tb_exec_stage.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_stage_if.sv
// exec_stage_if: bundles the controller handshake and the register-file
// port of the execute stage. The master side is the controller together
// with the register file; the slave side is exec_stage itself.
interface exec_stage_if;
  // controller -> execute stage
  logic        start;
  logic [1:0]  op;
  logic [1:0]  shift;
  logic [2:0]  rn;
  logic [2:0]  rm;
  logic [2:0]  rd;
  // register file -> execute stage (combinational read of readnum)
  logic [15:0] rf_data;
  // execute stage -> register file
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic [15:0] data_in;
  // execute stage -> controller
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [2:0]  status;

  modport master (
    output start, op, shift, rn, rm, rd, rf_data,
    input  readnum, writenum, write, data_in, busy, done, result, status
  );

  modport slave (
    input  start, op, shift, rn, rm, rd, rf_data,
    output readnum, writenum, write, data_in, busy, done, result, status
  );
endinterface

// File: rtl/exec_stage.sv
// exec_stage: sequences two register-file reads into operand latches A/B,
// shifts B, computes C = A op B' with {V,N,Z} status and writes C back.
// Optional feature macro: EXEC_STAGE_OVF_EN enables the overflow flag V;
// when it is undefined status[2] is constantly 0.
module exec_stage (
  input  logic        clk,
  input  logic        reset,
  exec_stage_if.slave bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RDA  = 3'd1;
  localparam logic [2:0] RDB  = 3'd2;
  localparam logic [2:0] EXEC = 3'd3;
  localparam logic [2:0] WB   = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  logic [2:0]  state_reg, state_next;
  logic [1:0]  op_reg, shift_reg;
  logic [2:0]  rm_reg, rd_reg;
  logic [15:0] a_reg, b_reg, c_reg;
  logic [2:0]  status_reg;
  logic [2:0]  readnum_reg, writenum_reg;

  logic        accept;
  logic [15:0] b_shifted;
  logic [15:0] alu_c;
  logic        alu_v;

  // A new operation is taken only when the stage is idle or just finishing.
  assign accept = ((state_reg == IDLE) || (state_reg == DONE)) && bus.start;

  // Next-state sequencing through the fixed five-cycle operation.
  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE:    state_next = accept ? RDA : IDLE;
      RDA:     state_next = RDB;
      RDB:     state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      state_next = DONE;
      DONE:    state_next = accept ? RDA : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Capture the operation fields at accept; they stay frozen until the next accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg    <= 2'b00;
      shift_reg <= 2'b00;
      rm_reg    <= 3'd0;
      rd_reg    <= 3'd0;
    end else if (accept) begin
      op_reg    <= bus.op;
      shift_reg <= bus.shift;
      rm_reg    <= bus.rm;
      rd_reg    <= bus.rd;
    end
  end

  // One-bit shifter applied to operand B.
  always_comb begin
    b_shifted = b_reg;
    case (shift_reg)
      2'b00: b_shifted = b_reg;
      2'b01: b_shifted = {b_reg[14:0], 1'b0};
      2'b10: b_shifted = {1'b0, b_reg[15:1]};
      2'b11: b_shifted = {b_reg[15], b_reg[15:1]};
      default: b_shifted = b_reg;
    endcase
  end

  // ALU and signed-overflow detection for add/subtract.
  always_comb begin
    alu_c = 16'h0000;
    alu_v = 1'b0;
    case (op_reg)
      2'b00: alu_c = a_reg + b_shifted;
      2'b01: alu_c = a_reg - b_shifted;
      2'b10: alu_c = a_reg & b_shifted;
      2'b11: alu_c = ~b_shifted;
      default: alu_c = 16'h0000;
    endcase
`ifdef EXEC_STAGE_OVF_EN
    if (op_reg == 2'b00)
      alu_v = (a_reg[15] == b_shifted[15]) && (alu_c[15] != a_reg[15]);
    else if (op_reg == 2'b01)
      alu_v = (a_reg[15] != b_shifted[15]) && (alu_c[15] != a_reg[15]);
    else
      alu_v = 1'b0;
`else
    alu_v = 1'b0;
`endif
  end

  // Operand and result latches: A in RDA, B in RDB, C and status in EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg      <= 16'h0000;
      b_reg      <= 16'h0000;
      c_reg      <= 16'h0000;
      status_reg <= 3'b000;
    end else begin
      if (state_reg == RDA) a_reg <= bus.rf_data;
      if (state_reg == RDB) b_reg <= bus.rf_data;
      if (state_reg == EXEC) begin
        c_reg      <= alu_c;
        status_reg <= {alu_v, alu_c[15], (alu_c == 16'h0000)};
      end
    end
  end

  // Register-file selects are registered so they hold between uses;
  // readnum points at rn during RDA, rm during RDB, writenum at rd during WB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readnum_reg  <= 3'd0;
      writenum_reg <= 3'd0;
    end else begin
      if (accept)             readnum_reg  <= bus.rn;
      else if (state_reg == RDA) readnum_reg  <= rm_reg;
      if (state_reg == EXEC)  writenum_reg <= rd_reg;
    end
  end

  assign bus.readnum  = readnum_reg;
  assign bus.writenum = writenum_reg;
  assign bus.write    = (state_reg == WB);
  assign bus.data_in  = c_reg;
  assign bus.busy     = (state_reg != IDLE);
  assign bus.done     = (state_reg == DONE);
  assign bus.result   = c_reg;
  assign bus.status   = status_reg;

endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: drives exec_stage against a behavioural 8x16 register file.
// Expected results are queued at issue; a monitor pops them on each done.
module tb_exec_stage;

`ifdef EXEC_STAGE_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  exec_stage_if ifc ();

  exec_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  // Behavioural register file with a bench-side preload port.
  logic [15:0] regs [8];
  logic        pre_we = 1'b0;
  logic [2:0]  pre_addr = 3'd0;
  logic [15:0] pre_data = 16'h0000;
  assign ifc.rf_data = regs[ifc.readnum];

  always @(posedge clk) begin
    if (ifc.write) regs[ifc.writenum] <= ifc.data_in;
    if (pre_we)    regs[pre_addr]     <= pre_data;
  end

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] c;
    logic [2:0]  st;
    int          issue;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_target = 0;
  int wr_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: counts write strobes and checks each completed operation.
  always @(negedge clk) begin
    exp_t e;
    if (ifc.write) wr_count++;
    if (!reset && ifc.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done_cnt), 32'(done_target));
      end else begin
        e = sb.pop_front();
        $display("op done rd=%0d result=%04h status=%03b cycle=%0d",
                 e.rd, ifc.result, ifc.status, cycle_cnt);
        chk("result", 32'(ifc.result), 32'(e.c));
        chk("status", 32'(ifc.status), 32'(e.st));
        chk("regfile_wb", 32'(regs[e.rd]), 32'(e.c));
        chk("latency", 32'(cycle_cnt - e.issue), 32'd5);
        chk("write_count", 32'(wr_count), 32'd1);
      end
      wr_count = 0;
    end
  end

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic set_fields(input logic [2:0] rn, rm, rd, input logic [1:0] op, sh);
    ifc.rn = rn; ifc.rm = rm; ifc.rd = rd; ifc.op = op; ifc.shift = sh;
  endtask

  task automatic push_exp(input logic [2:0] rd, input logic [15:0] c,
                          input logic v, input int issue);
    exp_t e;
    e.rd = rd; e.c = c;
    e.st = {(OVF_EN ? v : 1'b0), c[15], (c == 16'h0000)};
    e.issue = issue;
    sb.push_back(e);
    done_target++;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt < done_target && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done_cnt), 32'(done_target));
  endtask

  task automatic do_op(input logic [2:0] rn, rm, rd, input logic [1:0] op, sh,
                       input logic [15:0] c, input logic v);
    @(negedge clk);
    set_fields(rn, rm, rd, op, sh);
    ifc.start = 1'b1;
    push_exp(rd, c, v, cycle_cnt);
    @(posedge clk);
    @(negedge clk);
    ifc.start = 1'b0;
    wait_done();
  endtask

  initial begin
    int issue1;
    ifc.start = 1'b0;
    set_fields(3'd0, 3'd0, 3'd0, 2'b00, 2'b00);

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_done", 32'(ifc.done), 32'd0);
    chk("rst_write", 32'(ifc.write), 32'd0);
    chk("rst_result", 32'(ifc.result), 32'd0);
    chk("rst_status", 32'(ifc.status), 32'd0);
    chk("rst_readnum", 32'(ifc.readnum), 32'd0);
    chk("rst_writenum", 32'(ifc.writenum), 32'd0);
    reset = 1'b0;

    // Directed operations
    preload(3'd3, 16'd42);
    preload(3'd1, 16'd69);
    do_op(3'd3, 3'd1, 3'd2, 2'b00, 2'b00, 16'd111, 1'b0);
    preload(3'd0, 16'd5);
    preload(3'd1, 16'd5);
    do_op(3'd0, 3'd1, 3'd4, 2'b01, 2'b00, 16'd0, 1'b0);
    preload(3'd0, 16'h8000);
    preload(3'd1, 16'h0001);
    do_op(3'd0, 3'd1, 3'd5, 2'b01, 2'b00, 16'h7FFF, 1'b1);
    preload(3'd1, 16'h8002);
    do_op(3'd0, 3'd1, 3'd6, 2'b11, 2'b11, 16'h3FFE, 1'b0);
    do_op(3'd0, 3'd1, 3'd7, 2'b11, 2'b10, 16'hBFFE, 1'b0);

    // rd == rn == rm, with a start pulse during EXEC that must be ignored
    @(negedge clk);
    set_fields(3'd3, 3'd3, 3'd3, 2'b00, 2'b00);
    ifc.start = 1'b1;
    push_exp(3'd3, 16'd84, 1'b0, cycle_cnt);
    @(posedge clk);
    @(negedge clk);
    ifc.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    set_fields(3'd0, 3'd0, 3'd6, 2'b11, 2'b00);
    ifc.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.start = 1'b0;
    wait_done();
    repeat (8) @(negedge clk);
    chk("ignored_start_dones", 32'(done_cnt), 32'(done_target));
    chk("ignored_start_busy", 32'(ifc.busy), 32'd0);
    chk("ignored_start_r6", 32'(regs[6]), 32'h3FFE);

    // AND with left shift: 84 & (0x8002<<1)
    do_op(3'd3, 3'd1, 3'd1, 2'b10, 2'b01, 16'h0004, 1'b0);

    // Reset asserted during EXEC aborts without a write
    @(negedge clk);
    set_fields(3'd3, 3'd3, 3'd6, 2'b00, 2'b00);
    ifc.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(ifc.busy), 32'd0);
    chk("abort_write", 32'(ifc.write), 32'd0);
    chk("abort_done", 32'(ifc.done), 32'd0);
    chk("abort_result", 32'(ifc.result), 32'd0);
    chk("abort_status", 32'(ifc.status), 32'd0);
    chk("abort_readnum", 32'(ifc.readnum), 32'd0);
    chk("abort_writenum", 32'(ifc.writenum), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_r6", 32'(regs[6]), 32'h3FFE);
    chk("abort_writes", 32'(wr_count), 32'd0);
    chk("abort_dones", 32'(done_cnt), 32'(done_target));

    // Back-to-back with start held high through DONE
    preload(3'd2, 16'd10);
    preload(3'd4, 16'd3);
    @(negedge clk);
    set_fields(3'd2, 3'd4, 3'd7, 2'b00, 2'b00);
    ifc.start = 1'b1;
    issue1 = cycle_cnt;
    push_exp(3'd7, 16'd13, 1'b0, issue1);
    @(posedge clk);
    @(negedge clk);
    set_fields(3'd7, 3'd2, 3'd5, 2'b01, 2'b00);
    push_exp(3'd5, 16'd3, 1'b0, issue1 + 5);
    chk("b2b_busy", 32'(ifc.busy), 32'd1);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (cycle_cnt >= issue1 + 6) ifc.start = 1'b0;
      chk("b2b_busy", 32'(ifc.busy), 32'd1);
    end
    wait_done();

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
